aurora_clk_supervisor: RTL and testbench

Multi-channel clock supervisor for Aurora links. It sequences the reset of each channel's user/sync-clock MMCM against its GT PLL lock, qualifies MMCM lock with timeout and stability checks, and retries automatically. It latches a per-channel fault after repeated failures. Runs in the free-running init clock domain, between the GT wrappers and the per-channel MMCM clocking blocks. It replaces the direct "MMCM RST = !GT lock" tie.

---
 rtl/aurora_clk_supervisor_if.sv | 25 ++
 rtl/aurora_clk_supervisor.sv | 177 +++++++++++++++++
 tb/tb_aurora_clk_supervisor.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/aurora_clk_supervisor_if.sv
// Lock/reset/status bundle between the Aurora clock supervisor and its
// surroundings. The slave modport is the supervisor side.
interface aurora_clk_supervisor_if #(
   parameter int unsigned NCHAN     = 4,
   parameter int unsigned CNT_WIDTH = 8
);
   logic [NCHAN-1:0]           GT_LOCKED;
   logic [NCHAN-1:0]           MMCM_LOCKED;
   logic [NCHAN-1:0]           CLEAR_FAULT;
   logic [NCHAN-1:0]           MMCM_RESET;
   logic [NCHAN-1:0]           CLK_READY;
   logic [NCHAN-1:0]           FAULT;
   logic                       ALL_READY;
   logic [NCHAN*CNT_WIDTH-1:0] RELOCK_COUNT;

   modport master (
      output GT_LOCKED, MMCM_LOCKED, CLEAR_FAULT,
      input  MMCM_RESET, CLK_READY, FAULT, ALL_READY, RELOCK_COUNT
   );

   modport slave (
      input  GT_LOCKED, MMCM_LOCKED, CLEAR_FAULT,
      output MMCM_RESET, CLK_READY, FAULT, ALL_READY, RELOCK_COUNT
   );
endinterface

// File: rtl/aurora_clk_supervisor.sv
// Multi-channel Aurora clock supervisor: sequences each MMCM reset against its
// GT PLL lock, qualifies MMCM lock with timeout/stability, retries, and latches
// a fault after repeated failures.
// Optional feature: define AURORA_CLK_SUPERVISOR_RELOCK_COUNT_EN to build the
// per-channel relock counters; otherwise RELOCK_COUNT is tied to zero.
module aurora_clk_supervisor #(
   parameter int unsigned NCHAN         = 4,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned RST_CYCLES    = 128,
   parameter int unsigned LOCK_TIMEOUT  = 65536,
   parameter int unsigned STABLE_CYCLES = 1024,
   parameter int unsigned MAX_RETRIES   = 7,
   parameter int unsigned CNT_WIDTH     = 8
) (
   input logic                    INIT_CLK,
   input logic                    INIT_RESET_N,
   aurora_clk_supervisor_if.slave bus
);

   localparam int unsigned TMR_MAX_A = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
   localparam int unsigned TMR_MAX   = (LOCK_TIMEOUT > TMR_MAX_A) ? LOCK_TIMEOUT : TMR_MAX_A;
   localparam int unsigned TMR_W     = $clog2(TMR_MAX + 1);
   localparam int unsigned RTY_W     = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

   localparam logic [2:0] S_WAIT_GT   = 3'd0;
   localparam logic [2:0] S_HOLD      = 3'd1;
   localparam logic [2:0] S_WAIT_LOCK = 3'd2;
   localparam logic [2:0] S_STABLE    = 3'd3;
   localparam logic [2:0] S_READY     = 3'd4;
   localparam logic [2:0] S_RETRY     = 3'd5;
   localparam logic [2:0] S_FAULT     = 3'd6;

   logic [NCHAN-1:0]           mmcm_reset_w;
   logic [NCHAN-1:0]           clk_ready_w;
   logic [NCHAN-1:0]           fault_w;
   logic [NCHAN*CNT_WIDTH-1:0] relock_w;
   logic                       all_ready_q;

   for (genvar k = 0; k < NCHAN; k++) begin : g_chan
      logic [SYNC_STAGES-1:0] gt_sync;
      logic [SYNC_STAGES-1:0] mm_sync;
      logic                   gt;
      logic                   mm;
      logic [2:0]             state_q;
      logic [2:0]             state_d;
      logic [TMR_W-1:0]       tmr_q;
      logic                   tmr_run;
      logic [RTY_W-1:0]       rty_q;
      logic [RTY_W-1:0]       rty_d;
      logic                   relock_inc;
      logic                   mmcm_reset_q;
      logic                   clk_ready_q;
      logic                   fault_q;

      assign gt = gt_sync[SYNC_STAGES-1];
      assign mm = mm_sync[SYNC_STAGES-1];

      // Bring the asynchronous lock inputs into INIT_CLK.
      always_ff @(posedge INIT_CLK) begin
         if (!INIT_RESET_N) begin
            gt_sync <= '0;
            mm_sync <= '0;
         end else begin
            gt_sync <= {gt_sync[SYNC_STAGES-2:0], bus.GT_LOCKED[k]};
            mm_sync <= {mm_sync[SYNC_STAGES-2:0], bus.MMCM_LOCKED[k]};
         end
      end

      // Next state; loss of GT lock overrides every other exit condition.
      always_comb begin
         state_d    = state_q;
         rty_d      = rty_q;
         relock_inc = 1'b0;
         tmr_run    = 1'b0;
         unique case (state_q)
            S_WAIT_GT: begin
               if (gt) state_d = S_HOLD;
            end
            S_HOLD: begin
               tmr_run = 1'b1;
               if (!gt)                                     state_d = S_WAIT_GT;
               else if (tmr_q == TMR_W'(RST_CYCLES - 1))    state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
               tmr_run = 1'b1;
               if (!gt)                                     state_d = S_WAIT_GT;
               else if (mm)                                 state_d = S_STABLE;
               else if (tmr_q == TMR_W'(LOCK_TIMEOUT - 1))  state_d = S_RETRY;
            end
            S_STABLE: begin
               tmr_run = 1'b1;
               if (!gt)                                     state_d = S_WAIT_GT;
               else if (!mm)                                state_d = S_RETRY;
               else if (tmr_q == TMR_W'(STABLE_CYCLES - 1)) state_d = S_READY;
            end
            S_READY: begin
               rty_d = '0;
               if (!gt) begin
                  state_d    = S_WAIT_GT;
                  relock_inc = 1'b1;
               end else if (!mm) begin
                  state_d    = S_RETRY;
                  relock_inc = 1'b1;
               end
            end
            S_RETRY: begin
               if (rty_q == RTY_W'(MAX_RETRIES)) begin
                  state_d = S_FAULT;
               end else begin
                  rty_d   = rty_q + RTY_W'(1);
                  state_d = S_HOLD;
               end
            end
            S_FAULT: begin
               if (bus.CLEAR_FAULT[k]) begin
                  rty_d   = '0;
                  state_d = S_WAIT_GT;
               end
            end
            default: state_d = S_WAIT_GT;
         endcase
      end

      // State, timer, retry counter and outputs decoded from the next state.
      always_ff @(posedge INIT_CLK) begin
         if (!INIT_RESET_N) begin
            state_q      <= S_WAIT_GT;
            tmr_q        <= '0;
            rty_q        <= '0;
            mmcm_reset_q <= 1'b1;
            clk_ready_q  <= 1'b0;
            fault_q      <= 1'b0;
         end else begin
            state_q <= state_d;
            rty_q   <= rty_d;
            if (state_d != state_q) tmr_q <= '0;
            else if (tmr_run)       tmr_q <= tmr_q + TMR_W'(1);
            mmcm_reset_q <= (state_d == S_WAIT_GT) || (state_d == S_HOLD) || (state_d == S_FAULT);
            clk_ready_q  <= (state_d == S_READY);
            fault_q      <= (state_d == S_FAULT);
         end
      end

      assign mmcm_reset_w[k] = mmcm_reset_q;
      assign clk_ready_w[k]  = clk_ready_q;
      assign fault_w[k]      = fault_q;

`ifdef AURORA_CLK_SUPERVISOR_RELOCK_COUNT_EN
      logic [CNT_WIDTH-1:0] relock_q;

      // Saturating count of lock losses out of READY.
      always_ff @(posedge INIT_CLK) begin
         if (!INIT_RESET_N)                         relock_q <= '0;
         else if (relock_inc && (relock_q != '1))   relock_q <= relock_q + CNT_WIDTH'(1);
      end

      assign relock_w[k*CNT_WIDTH +: CNT_WIDTH] = relock_q;
`else
      logic unused_relock_inc;
      assign unused_relock_inc = relock_inc;
      assign relock_w[k*CNT_WIDTH +: CNT_WIDTH] = '0;
`endif
   end

   // Aggregate readiness, one cycle behind the per-channel flags.
   always_ff @(posedge INIT_CLK) begin
      if (!INIT_RESET_N) all_ready_q <= 1'b0;
      else               all_ready_q <= &clk_ready_w;
   end

   assign bus.MMCM_RESET   = mmcm_reset_w;
   assign bus.CLK_READY    = clk_ready_w;
   assign bus.FAULT        = fault_w;
   assign bus.ALL_READY    = all_ready_q;
   assign bus.RELOCK_COUNT = relock_w;

endmodule

// File: tb/tb_aurora_clk_supervisor.sv
// Directed bench for aurora_clk_supervisor with small timing parameters.
// Cycle c means 1 time unit after the c-th rising edge following reset release;
// inputs driven at cycle c are first sampled on edge c+1.
module tb_aurora_clk_supervisor;

   localparam int unsigned NCHAN = 2;
   localparam int unsigned CW    = 8;
`ifdef AURORA_CLK_SUPERVISOR_RELOCK_COUNT_EN
   localparam logic [CW-1:0] EXP_RELOCK1 = 8'd1;
`else
   localparam logic [CW-1:0] EXP_RELOCK1 = 8'd0;
`endif

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_cmp;
   int   n_err;

   aurora_clk_supervisor_if #(.NCHAN(NCHAN), .CNT_WIDTH(CW)) bus ();

   aurora_clk_supervisor #(
      .NCHAN(NCHAN), .SYNC_STAGES(2), .RST_CYCLES(4), .LOCK_TIMEOUT(16),
      .STABLE_CYCLES(8), .MAX_RETRIES(2), .CNT_WIDTH(CW)
   ) dut (
      .INIT_CLK(clk),
      .INIT_RESET_N(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int c);
      while (cyc < c) tick();
   endtask

   task automatic apply_reset();
      rst_n           = 1'b0;
      bus.GT_LOCKED   = '0;
      bus.MMCM_LOCKED = '0;
      bus.CLEAR_FAULT = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      cyc   = 0;
   endtask

   task automatic test_reset();
      rst_n           = 1'b0;
      bus.GT_LOCKED   = '0;
      bus.MMCM_LOCKED = '0;
      bus.CLEAR_FAULT = '0;
      repeat (3) tick();
      n_cmp++; if (bus.MMCM_RESET !== 2'b11) begin n_err++; $display("FAIL rst_mmcm_reset got %b want 11", bus.MMCM_RESET); end
      n_cmp++; if (bus.CLK_READY !== 2'b00) begin n_err++; $display("FAIL rst_clk_ready got %b want 00", bus.CLK_READY); end
      n_cmp++; if (bus.FAULT !== 2'b00) begin n_err++; $display("FAIL rst_fault got %b want 00", bus.FAULT); end
      n_cmp++; if (bus.ALL_READY !== 1'b0) begin n_err++; $display("FAIL rst_all_ready got %b want 0", bus.ALL_READY); end
      n_cmp++; if (bus.RELOCK_COUNT !== 16'h0) begin n_err++; $display("FAIL rst_relock got %h want 0000", bus.RELOCK_COUNT); end
   endtask

   task automatic test_bringup();
      apply_reset();
      bus.GT_LOCKED[0] = 1'b1;
      for (int c = 0; c <= 6; c++) begin
         run_to(c);
         n_cmp++; if (bus.MMCM_RESET[0] !== 1'b1) begin n_err++; $display("FAIL bringup_hold c=%0d got %b want 1", c, bus.MMCM_RESET[0]); end
      end
      run_to(7);
      n_cmp++; if (bus.MMCM_RESET[0] !== 1'b0) begin n_err++; $display("FAIL bringup_release got %b want 0", bus.MMCM_RESET[0]); end
      run_to(10);
      bus.MMCM_LOCKED[0] = 1'b1;
      run_to(20);
      n_cmp++; if (bus.CLK_READY[0] !== 1'b0) begin n_err++; $display("FAIL bringup_early_ready got %b want 0", bus.CLK_READY[0]); end
      run_to(21);
      n_cmp++; if (bus.CLK_READY[0] !== 1'b1) begin n_err++; $display("FAIL bringup_ready got %b want 1", bus.CLK_READY[0]); end
      run_to(22);
      n_cmp++; if (bus.ALL_READY !== 1'b0) begin n_err++; $display("FAIL bringup_all_ready got %b want 0", bus.ALL_READY); end
   endtask

   task automatic test_relock();
      apply_reset();
      bus.GT_LOCKED   = 2'b11;
      bus.MMCM_LOCKED = 2'b11;
      run_to(16);
      n_cmp++; if (bus.CLK_READY !== 2'b11) begin n_err++; $display("FAIL relock_both_ready got %b want 11", bus.CLK_READY); end
      run_to(17);
      n_cmp++; if (bus.ALL_READY !== 1'b1) begin n_err++; $display("FAIL relock_all_ready got %b want 1", bus.ALL_READY); end
      run_to(20);
      bus.MMCM_LOCKED[1] = 1'b0;
      run_to(21);
      bus.MMCM_LOCKED[1] = 1'b1;
      run_to(22);
      n_cmp++; if (bus.CLK_READY[1] !== 1'b1) begin n_err++; $display("FAIL relock_pre_drop got %b want 1", bus.CLK_READY[1]); end
      run_to(23);
      n_cmp++; if (bus.CLK_READY[1] !== 1'b0) begin n_err++; $display("FAIL relock_ready_drop got %b want 0", bus.CLK_READY[1]); end
      n_cmp++; if (bus.MMCM_RESET[1] !== 1'b0) begin n_err++; $display("FAIL relock_retry_rst got %b want 0", bus.MMCM_RESET[1]); end
      run_to(24);
      n_cmp++; if (bus.ALL_READY !== 1'b0) begin n_err++; $display("FAIL relock_all_drop got %b want 0", bus.ALL_READY); end
      for (int c = 24; c <= 27; c++) begin
         run_to(c);
         n_cmp++; if (bus.MMCM_RESET[1] !== 1'b1) begin n_err++; $display("FAIL relock_pulse c=%0d got %b want 1", c, bus.MMCM_RESET[1]); end
      end
      n_cmp++; if (bus.RELOCK_COUNT[CW +: CW] !== EXP_RELOCK1) begin n_err++; $display("FAIL relock_count1 got %0d want %0d", bus.RELOCK_COUNT[CW +: CW], EXP_RELOCK1); end
      n_cmp++; if (bus.RELOCK_COUNT[0 +: CW] !== 8'd0) begin n_err++; $display("FAIL relock_count0 got %0d want 0", bus.RELOCK_COUNT[0 +: CW]); end
      n_cmp++; if (bus.CLK_READY[0] !== 1'b1) begin n_err++; $display("FAIL relock_ch0_undisturbed got %b want 1", bus.CLK_READY[0]); end
      run_to(28);
      n_cmp++; if (bus.MMCM_RESET[1] !== 1'b0) begin n_err++; $display("FAIL relock_pulse_end got %b want 0", bus.MMCM_RESET[1]); end
      run_to(36);
      n_cmp++; if (bus.CLK_READY[1] !== 1'b0) begin n_err++; $display("FAIL relock_early got %b want 0", bus.CLK_READY[1]); end
      run_to(37);
      n_cmp++; if (bus.CLK_READY !== 2'b11) begin n_err++; $display("FAIL relock_ready_again got %b want 11", bus.CLK_READY); end
      run_to(38);
      n_cmp++; if (bus.ALL_READY !== 1'b1) begin n_err++; $display("FAIL relock_all_again got %b want 1", bus.ALL_READY); end
   endtask

   // Continues from test_relock with both channels READY.
   task automatic test_reset_mid();
      run_to(40);
      rst_n = 1'b0;
      run_to(41);
      n_cmp++; if (bus.MMCM_RESET !== 2'b11) begin n_err++; $display("FAIL midrst_mmcm_reset got %b want 11", bus.MMCM_RESET); end
      n_cmp++; if (bus.CLK_READY !== 2'b00) begin n_err++; $display("FAIL midrst_clk_ready got %b want 00", bus.CLK_READY); end
      n_cmp++; if (bus.ALL_READY !== 1'b0) begin n_err++; $display("FAIL midrst_all_ready got %b want 0", bus.ALL_READY); end
      n_cmp++; if (bus.RELOCK_COUNT !== 16'h0) begin n_err++; $display("FAIL midrst_relock got %h want 0000", bus.RELOCK_COUNT); end
   endtask

   task automatic test_fault();
      logic exp_rst;
      apply_reset();
      bus.GT_LOCKED[0] = 1'b1;
      for (int c = 0; c <= 66; c++) begin
         run_to(c);
         exp_rst = (c < 7) || (c >= 24 && c <= 27) || (c >= 45 && c <= 48) || (c >= 66);
         n_cmp++; if (bus.MMCM_RESET[0] !== exp_rst) begin n_err++; $display("FAIL fault_seq c=%0d got %b want %b", c, bus.MMCM_RESET[0], exp_rst); end
         // A clear outside FAULT must be ignored.
         bus.CLEAR_FAULT[0] = (c == 30);
      end
      n_cmp++; if (bus.FAULT[0] !== 1'b1) begin n_err++; $display("FAIL fault_set got %b want 1", bus.FAULT[0]); end
      run_to(70);
      n_cmp++; if (bus.FAULT[0] !== 1'b1) begin n_err++; $display("FAIL fault_latched got %b want 1", bus.FAULT[0]); end
      bus.CLEAR_FAULT[0] = 1'b1;
      run_to(71);
      bus.CLEAR_FAULT[0] = 1'b0;
      n_cmp++; if (bus.FAULT[0] !== 1'b0) begin n_err++; $display("FAIL fault_clear got %b want 0", bus.FAULT[0]); end
      run_to(75);
      n_cmp++; if (bus.MMCM_RESET[0] !== 1'b1) begin n_err++; $display("FAIL fault_new_hold got %b want 1", bus.MMCM_RESET[0]); end
      run_to(76);
      n_cmp++; if (bus.MMCM_RESET[0] !== 1'b0) begin n_err++; $display("FAIL fault_new_wait got %b want 0", bus.MMCM_RESET[0]); end
   endtask

   task automatic test_gt_drop_at_timeout();
      apply_reset();
      bus.GT_LOCKED[0] = 1'b1;
      run_to(20);
      bus.GT_LOCKED[0] = 1'b0;
      run_to(23);
      n_cmp++; if (bus.MMCM_RESET[0] !== 1'b1) begin n_err++; $display("FAIL gtdrop_wait_gt got %b want 1", bus.MMCM_RESET[0]); end
      run_to(25);
      bus.GT_LOCKED[0] = 1'b1;
      run_to(27);
      n_cmp++; if (bus.MMCM_RESET[0] !== 1'b1) begin n_err++; $display("FAIL gtdrop_still_reset got %b want 1", bus.MMCM_RESET[0]); end
      run_to(48);
      n_cmp++; if (bus.MMCM_RESET[0] !== 1'b0) begin n_err++; $display("FAIL gtdrop_retry1 got %b want 0", bus.MMCM_RESET[0]); end
      run_to(49);
      n_cmp++; if (bus.MMCM_RESET[0] !== 1'b1) begin n_err++; $display("FAIL gtdrop_hold2 got %b want 1", bus.MMCM_RESET[0]); end
      run_to(70);
      n_cmp++; if (bus.MMCM_RESET[0] !== 1'b1) begin n_err++; $display("FAIL gtdrop_hold3 got %b want 1", bus.MMCM_RESET[0]); end
      n_cmp++; if (bus.FAULT[0] !== 1'b0) begin n_err++; $display("FAIL gtdrop_no_fault got %b want 0", bus.FAULT[0]); end
      run_to(71);
      n_cmp++; if (bus.FAULT[0] !== 1'b0) begin n_err++; $display("FAIL gtdrop_no_fault2 got %b want 0", bus.FAULT[0]); end
   endtask

   task automatic test_stable_toggle();
      apply_reset();
      bus.GT_LOCKED[0]   = 1'b1;
      bus.MMCM_LOCKED[0] = 1'b1;
      for (int c = 0; c <= 34; c++) begin
         run_to(c);
         n_cmp++; if (bus.CLK_READY[0] !== 1'b0) begin n_err++; $display("FAIL toggle_ready c=%0d got %b want 0", c, bus.CLK_READY[0]); end
         if (c == 14 || c == 24) begin
            n_cmp++; if (bus.MMCM_RESET[0] !== 1'b1) begin n_err++; $display("FAIL toggle_retry_hold c=%0d got %b want 1", c, bus.MMCM_RESET[0]); end
         end
         if (c == 13 || c == 23) begin
            n_cmp++; if (bus.MMCM_RESET[0] !== 1'b0) begin n_err++; $display("FAIL toggle_retry c=%0d got %b want 0", c, bus.MMCM_RESET[0]); end
         end
         if (c == 33) begin
            n_cmp++; if (bus.FAULT[0] !== 1'b0) begin n_err++; $display("FAIL toggle_fault_early got %b want 0", bus.FAULT[0]); end
         end
         if (c == 34) begin
            n_cmp++; if (bus.FAULT[0] !== 1'b1) begin n_err++; $display("FAIL toggle_fault got %b want 1", bus.FAULT[0]); end
         end
         bus.MMCM_LOCKED[0] = (c < 10) ? 1'b1 : (((c - 10) / 5) % 2 == 1);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      cyc   = 0;
      test_reset();
      test_bringup();
      test_relock();
      test_reset_mid();
      test_fault();
      test_gt_drop_at_timeout();
      test_stable_toggle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
